cycle_shift_register_param: RTL

//  Parametrised multi-cycle rotate/shift register. This is the successor to the fixed
//  16-bit left-rotate register. It loads a WIDTH-bit word and then, on command, rotates
//  or logically shifts it left or right by a run-time amount.
//  The amount is processed at STEP bits per clock, and a start/busy/done handshake

---
 rtl/cycle_shift_register_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/cycle_shift_register_param.sv
// rtl/cycle_shift_register_param.sv - multi-cycle rotate/logical-shift register, STEP bits per clock
module cycle_shift_register_param #(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] din,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_mode,
  input  logic [AMT_W-1:0] i_amt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [AMT_W-1:0]   step_amt;
  logic [2*WIDTH-1:0] dbl_l, dbl_r;
  logic [WIDTH-1:0]   rot_l, rot_r;

  always_comb begin
    step_amt = (count_q < STEP_A) ? count_q : STEP_A;
    dbl_l    = {dout_q, dout_q} << step_amt;
    dbl_r    = {dout_q, dout_q} >> step_amt;
    rot_l    = dbl_l[2*WIDTH-1:WIDTH];
    rot_r    = dbl_r[WIDTH-1:0];
  end

  // The bit that wraps into the vacated end of a rotate is exactly the bit that
  // leaves the word, so the rotated word also supplies the carry for plain shifts.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          dout_d = din;
        end else if (i_start) begin
          dir_d   = i_dir;
          mode_d  = i_mode;
          count_d = i_amt;
          state_d = (i_amt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!dir_q) begin
          dout_d  = mode_q ? (dout_q << step_amt) : rot_l;
          carry_d = rot_l[0];
        end else begin
          dout_d  = mode_q ? (dout_q >> step_amt) : rot_r;
          carry_d = rot_r[WIDTH-1];
        end
        count_d = count_q - step_amt;
        if (count_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout    = dout_q;
  assign o_carry = carry_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
